sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, next generation of the team's 8-bit × 512 buffer.
- Data width, depth and almost-full/almost-empty thresholds are parameters.
- Adds an occupancy count, a read-valid strobe and sticky overflow/underflow error flags.
- Sits between stream producers and consumers in the same clock domain, e.g. UART/SPI byte buffering and DMA staging.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 9, address width; DEPTH = 2**ADDR_W entries
AFULL_TH, 480, almost_full asserts when occupancy >= AFULL_TH (legal range 1..DEPTH)
AEMPTY_TH, 32, almost_empty asserts when occupancy <= AEMPTY_TH (legal range 0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
wr_data  input  DATA_W  write data
rd_en  input  1  read request (acknowledge in FWFT mode)
rd_data  output  DATA_W  read data
rd_valid  output  1  rd_data holds a freshly read word
full  output  1  no write accepted
empty  output  1  no read accepted
almost_full  output  1  occupancy >= AFULL_TH
almost_empty  output  1  occupancy <= AEMPTY_TH
count  output  ADDR_W+1  RAM occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  clears overflow/underflow

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- Reset values: pointers 0, count 0, full 0, empty 1, almost_full 0, almost_empty 1, rd_data 0, rd_valid 0, overflow 0, underflow 0. RAM contents are not reset.
- rst overrides all other inputs. Reset mid-operation discards all stored data; the next cycle behaves as a freshly reset FIFO.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit.
  - RAM address = ptr[ADDR_W-1:0]. Wrap from DEPTH-1 to 0 is natural binary rollover.
- Acceptance:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
  - Gating uses the registered flags of the current cycle.
- Next pointers: ptr_next = ptr + acc.
- Flag and count updates, all registered on the same edge as the pointers so they reflect post-edge state:
  - empty <= (wr_ptr_next == rd_ptr_next).
  - full <= low bits equal and wrap bits differ.
  - count <= wr_ptr_next - rd_ptr_next, modulo 2**(ADDR_W+1).
  - almost_full <= count_next >= AFULL_TH.
  - almost_empty <= count_next <= AEMPTY_TH.
- Simultaneous write and read:
  - Non-empty, non-full: both accepted; count unchanged.
  - Full: only the read is accepted, since full gates the write; count drops by 1 and full deasserts.
  - Empty: only the write is accepted; empty deasserts next edge.
- Standard read latency is 1 cycle: rd_acc at edge N gives rd_data = mem[rd_addr] and rd_valid = 1 after edge N.
  - rd_valid is 0 in any cycle without rd_acc.
  - rd_data holds its last value otherwise.
- Write-to-read: a word written at edge N is readable (empty = 0) in the cycle after edge N.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both clear on clr_err.
  - Set wins over clear in the same cycle.
  - Rejected requests never move pointers or corrupt RAM.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - A one-entry output register prefetches the head word.
  - rd_valid = output register occupied; rd_data always shows the head word while rd_valid = 1.
  - rd_en & rd_valid consumes the word.
  - The output register refills from RAM on the same edge if RAM is non-empty.
  - A write into a totally empty FIFO at edge N gives rd_valid = 1 after edge N+1.
  - empty = !rd_valid.
  - count/full/almost flags reflect RAM occupancy only, so total capacity is DEPTH+1.
  - underflow sets on rd_en & !rd_valid.
- Undefined: standard 1-cycle registered-read behaviour as above.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2;
  - localparam DEPTH derivation helper;
  - flag-compare helper (full/empty from pointer pair).
- One sub-module, sync_fifo_ram: simple dual-port RAM, DATA_W × DEPTH, synchronous write, registered read with read enable; inferable as block RAM.

Test Plan:
- Reset then idle: empty=1, almost_empty=1, count=0, rd_valid=0, rd_data=0 for 10 cycles.
- Write 0x00..0x1FF (DATA_W=8, ADDR_W=9) with no reads: full=1 after the 512th write edge, count=512, almost_full=1 from count 480; a 513th write sets overflow and count stays 512.
- Read all 512 words: data in order 0x00..0xFF,0x00..0xFF, rd_valid one cycle after each rd_en, empty=1 after the last; an extra rd_en sets underflow and rd_valid stays 0.
- Simultaneous wr_en&rd_en for 1000 cycles at count=5 with random data: count stays 5, output order matches a scoreboard, and both pointers wrap with no flag glitch; repeat at full (count 512→511) and at empty (count 0→1, rd_valid=0).
- clr_err asserted with overflow=1 and no new error: overflow=0 next cycle; clr_err asserted with wr_en&full in the same cycle: overflow stays 1.
- With SYNC_FIFO_FWFT_EN defined, write 0xA5 into an empty FIFO: rd_valid=1, rd_data=0xA5 two edges later without rd_en; rd_en for one cycle gives rd_valid=0 and empty=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing and pointer-compare helpers for sync_fifo_param
package sync_fifo_pkg;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of RAM entries for a given address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  // Full: addresses match but the wrap bits differ.
  function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                    input int addr_w);
    logic [31:0] low_mask;
    low_mask = (32'd1 << addr_w) - 32'd1;
    return (((wp ^ rp) & low_mask) == 32'd0) && (wp[addr_w] != rp[addr_w]);
  endfunction

  // Empty: pointers identical including the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp);
    return wp == rp;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port RAM, synchronous write, registered read
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write port; contents are never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register with sync reset (block RAM output latch reset).
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO; SYNC_FIFO_FWFT_EN selects first-word-fall-through
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 9,
  parameter int AFULL_TH  = 480,
  parameter int AEMPTY_TH = 32
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [ADDR_W:0] count_q, count_next;
  logic            full_q, ram_empty_q, afull_q, aempty_q;
  logic            ovf_q, udf_q, valid_q;
  logic            wr_acc, ram_rd, rd_bad;

  assign wr_acc = bus.wr_en & ~full_q;

`ifdef SYNC_FIFO_FWFT_EN
  // The RAM output register doubles as the prefetch stage: refill it when
  // empty or when the consumer takes the current head this cycle.
  assign ram_rd = ~ram_empty_q & (~valid_q | bus.rd_en);
  assign rd_bad = bus.rd_en & ~valid_q;
`else
  assign ram_rd = bus.rd_en & ~ram_empty_q;
  assign rd_bad = bus.rd_en & ram_empty_q;
`endif

  assign wr_ptr_next = wr_ptr + {{ADDR_W{1'b0}}, wr_acc};
  assign rd_ptr_next = rd_ptr + {{ADDR_W{1'b0}}, ram_rd};
  assign count_next  = wr_ptr_next - rd_ptr_next;

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (bus.wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (bus.rd_data)
  );

  // Pointers and all occupancy flags advance together so they describe post-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ram_empty_q <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      count_q     <= count_next;
      full_q      <= ptr_full(32'(wr_ptr_next), 32'(rd_ptr_next), ADDR_W);
      ram_empty_q <= ptr_empty(32'(wr_ptr_next), 32'(rd_ptr_next));
      afull_q     <= count_next >= AFULL_C;
      aempty_q    <= count_next <= AEMPTY_C;
    end
  end

  // Read-valid: a one-cycle strobe, or in FWFT mode the output-stage occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
`ifdef SYNC_FIFO_FWFT_EN
      valid_q <= ram_rd | (valid_q & ~bus.rd_en);
`else
      valid_q <= ram_rd;
`endif
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.wr_en & full_q) | (ovf_q & ~bus.clr_err);
      udf_q <= rd_bad | (udf_q & ~bus.clr_err);
    end
  end

  assign bus.rd_valid     = valid_q;
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.empty        = ~valid_q;
`else
  assign bus.empty        = ram_empty_q;
`endif
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(8), .ADDR_W(9)) bus ();

  sync_fifo_param #(
    .DATA_W(8), .ADDR_W(9), .AFULL_TH(480), .AEMPTY_TH(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       emp;
    logic       rv;
    logic [7:0] rdd;
    logic       udf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.clr_err = clr;
  endtask

  vec_t       vt[13];
  logic [7:0] sb[$];
  logic [7:0] wd;
  logic [7:0] exp_d;

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_empty", bus.empty, 1);
      check("idle_aempty", bus.almost_empty, 1);
      check("idle_count", bus.count, 0);
      check("idle_rd_valid", bus.rd_valid, 0);
      check("idle_rd_data", bus.rd_data, 0);
    end

`ifndef SYNC_FIFO_FWFT_EN
    vt[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hA1, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'hA1, 1'b0};
    vt[4]  = '{1'b1, 8'hC3, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hB2, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'hC3, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'hC3, 1'b1};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'hC3, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'hC3, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'hC3, 1'b0};
    vt[10] = '{1'b1, 8'hD4, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'hC3, 1'b1};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'hD4, 1'b1};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'hD4, 1'b0};

    for (int v = 0; v < 13; v++) begin
      drive(vt[v].wr, vt[v].d, vt[v].rd, vt[v].clr);
      step();
      check($sformatf("vec%0d_count", v), bus.count, vt[v].cnt);
      check($sformatf("vec%0d_empty", v), bus.empty, vt[v].emp);
      check($sformatf("vec%0d_rd_valid", v), bus.rd_valid, vt[v].rv);
      check($sformatf("vec%0d_rd_data", v), bus.rd_data, vt[v].rdd);
      check($sformatf("vec%0d_underflow", v), bus.underflow, vt[v].udf);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to capacity.
    for (int i = 0; i < 512; i++) begin
      wd = i[7:0];
      drive(1'b1, wd, 1'b0, 1'b0);
      step();
      check("fill_count", bus.count, i + 1);
      check("fill_afull", bus.almost_full, (i + 1) >= 480);
      check("fill_aempty", bus.almost_empty, (i + 1) <= 32);
      check("fill_full", bus.full, (i + 1) == 512);
      check("fill_empty", bus.empty, 0);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    step();
    check("ovf_set", bus.overflow, 1);
    check("ovf_count", bus.count, 512);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    step();
    check("ovf_set_wins", bus.overflow, 1);
    check("ovf_set_wins_count", bus.count, 512);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("ovf_clear", bus.overflow, 0);

    // Simultaneous write and read while full: only the read goes through.
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    step();
    check("wr_rd_full_count", bus.count, 511);
    check("wr_rd_full_full", bus.full, 0);
    check("wr_rd_full_rv", bus.rd_valid, 1);
    check("wr_rd_full_data", bus.rd_data, 8'h00);
    check("wr_rd_full_ovf", bus.overflow, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();

    // Drain the rest in order.
    for (int i = 0; i < 511; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      exp_d = 8'(i + 1);
      check("drain_rv", bus.rd_valid, 1);
      check("drain_data", bus.rd_data, exp_d);
      check("drain_count", bus.count, 510 - i);
    end
    check("drain_empty", bus.empty, 1);
    check("drain_aempty", bus.almost_empty, 1);
    check("drain_afull", bus.almost_full, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check("udf_set", bus.underflow, 1);
    check("udf_rv", bus.rd_valid, 0);
    check("udf_count", bus.count, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("udf_clear", bus.underflow, 0);

    // Steady state at count 5 with both pointers wrapping.
    for (int i = 0; i < 5; i++) begin
      wd = 8'($urandom);
      sb.push_back(wd);
      drive(1'b1, wd, 1'b0, 1'b0);
      step();
    end
    check("steady_start_count", bus.count, 5);
    for (int i = 0; i < 1000; i++) begin
      wd = 8'($urandom);
      sb.push_back(wd);
      drive(1'b1, wd, 1'b1, 1'b0);
      step();
      exp_d = sb.pop_front();
      check("steady_count", bus.count, 5);
      check("steady_rv", bus.rd_valid, 1);
      check("steady_data", bus.rd_data, exp_d);
      check("steady_flags", {bus.full, bus.empty}, 0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-operation discards the stored words.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_rd_data", bus.rd_data, 0);
    check("mid_rst_rv", bus.rd_valid, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check("mid_rst_read_rejected", bus.rd_valid, 0);
    check("mid_rst_udf", bus.underflow, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
`else
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    step();
    check("fwft_n_rv", bus.rd_valid, 0);
    check("fwft_n_empty", bus.empty, 1);
    check("fwft_n_count", bus.count, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("fwft_n1_rv", bus.rd_valid, 1);
    check("fwft_n1_data", bus.rd_data, 8'hA5);
    check("fwft_n1_empty", bus.empty, 0);
    check("fwft_n1_count", bus.count, 0);
    step();
    check("fwft_hold_rv", bus.rd_valid, 1);
    check("fwft_hold_data", bus.rd_data, 8'hA5);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check("fwft_pop_rv", bus.rd_valid, 0);
    check("fwft_pop_empty", bus.empty, 1);
    check("fwft_pop_udf", bus.underflow, 0);
    step();
    check("fwft_udf", bus.underflow, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
